// File: rtl/db_ram_slave_if.sv
// CPU data-bus bundle between the core (master) and the RAM slave.
interface db_ram_slave_if;
  logic [31:0] db_addr;
  logic [31:0] db_dataOut;
  logic [1:0]  db_accessType;
  logic [31:0] db_dataIn;
  logic        db_ready;
  logic        db_err;

  modport master (
    output db_addr, db_dataOut, db_accessType,
    input  db_dataIn, db_ready, db_err
  );

  modport slave (
    input  db_addr, db_dataOut, db_accessType,
    output db_dataIn, db_ready, db_err
  );
endinterface

// File: rtl/db_ram_slave.sv
// Word-addressed RAM slave with programmable wait states and one-cycle db_ready.
// Optional completion trace enabled by defining DB_RAM_TRACE_EN.
//
// state | meaning
// IDLE  | waiting for a request; accepts any non-NONE access type
// BUSY  | counting down wait states on the latched request
// ACK   | db_ready pulse; request inputs ignored
module db_ram_slave #(
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         res,
  db_ram_slave_if.slave bus
);

  localparam logic [1:0]  ACC_NONE  = 2'd0;
  localparam logic [1:0]  ACC_R     = 2'd1;
  localparam logic [1:0]  ACC_W     = 2'd2;
  localparam logic [1:0]  ACC_X     = 2'd3;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
  localparam int          DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, data_q;
  logic [1:0]              type_q;
  logic                    accept, do_access;
  logic [31:0]             acc_addr, acc_data;
  logic [1:0]              acc_type;
  logic                    acc_err;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.db_accessType != ACC_NONE) begin
          accept = 1'b1;
          cnt_d  = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d   = ACK;
            do_access = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ACK;
          do_access = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so use the live inputs.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr = bus.db_addr;
      acc_data = bus.db_dataOut;
      acc_type = bus.db_accessType;
    end else begin
      acc_addr = addr_q;
      acc_data = data_q;
      acc_type = type_q;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    acc_idx = acc_addr[ADDR_WIDTH+1:2];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      addr_q        <= 32'd0;
      data_q        <= 32'd0;
      type_q        <= ACC_NONE;
      bus.db_ready  <= 1'b0;
      bus.db_err    <= 1'b0;
      bus.db_dataIn <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus.db_ready <= do_access;
      bus.db_err   <= do_access & acc_err;
      if (accept) begin
        addr_q <= bus.db_addr;
        data_q <= bus.db_dataOut;
        type_q <= bus.db_accessType;
      end
      if (do_access && (acc_type == ACC_R || acc_type == ACC_X))
        bus.db_dataIn <= acc_err ? ERR_DATA : mem[acc_idx];
    end
  end

  // RAM has no reset; res gating keeps a reset-time request from writing.
  always_ff @(posedge clk) begin
    if (res && do_access && acc_type == ACC_W && !acc_err)
      mem[acc_idx] <= acc_data;
  end

`ifdef DB_RAM_TRACE_EN
`ifndef FONT_YELLOW
`define FONT_YELLOW "\033[1;33m"
`endif
`ifndef FONT_RESET
`define FONT_RESET "\033[0m"
`endif
  always @(posedge clk) begin
    if (res && state_q == ACK) begin
      if (type_q == ACC_X)
        $display("%sdb_ram X addr=%h data=%h err=%0d%s", `FONT_YELLOW, addr_q,
                 bus.db_dataIn, bus.db_err, `FONT_RESET);
      else if (type_q == ACC_W)
        $display("db_ram W addr=%h data=%h err=%0d", addr_q, data_q, bus.db_err);
      else
        $display("db_ram R addr=%h data=%h err=%0d", addr_q, bus.db_dataIn, bus.db_err);
    end
  end
`endif

endmodule

// File: tb/tb_db_ram_slave.sv
// Randomized bench for db_ram_slave: two instances (2 and 0 wait states) against a word-array model.
module tb_db_ram_slave;

  localparam logic [1:0] NONE = 2'd0, RD = 2'd1, WR = 2'd2, EX = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res2, res0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  db_ram_slave_if bus2();
  db_ram_slave_if bus0();

  db_ram_slave #(.ADDR_WIDTH(7), .WAIT_CYCLES(2)) dut2 (.clk(clk), .res(res2), .bus(bus2));
  db_ram_slave #(.ADDR_WIDTH(7), .WAIT_CYCLES(0)) dut0 (.clk(clk), .res(res0), .bus(bus0));

  int n_vec = 0, n_miss = 0;

  // s = 0 selects the 2-wait instance, s = 1 the 0-wait instance
  logic [31:0] ref_mem [2][128];
  logic [31:0] ref_out [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic drive(input int s, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus2.db_accessType = t; bus2.db_addr = a; bus2.db_dataOut = d;
    end else begin
      bus0.db_accessType = t; bus0.db_addr = a; bus0.db_dataOut = d;
    end
  endtask

  task automatic sense(input int s, output logic r, output logic e, output logic [31:0] q);
    if (s == 0) begin
      r = bus2.db_ready; e = bus2.db_err; q = bus2.db_dataIn;
    end else begin
      r = bus0.db_ready; e = bus0.db_err; q = bus0.db_dataIn;
    end
  endtask

  // mode 0: hold request until ready; 1: drop to NONE/0 after acceptance; 2: random junk after acceptance
  task automatic txn(input int s, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                     input int mode, output int done_cyc);
    logic r, e, err;
    logic [31:0] q;
    int lat;
    @(negedge clk);
    sense(s, r, e, q);
    check("idle_ready", {31'd0, r}, 32'd0);
    drive(s, t, a, d);
    lat = 0;
    r = 1'b0;
    while (!r && lat < 40) begin
      @(negedge clk);
      lat++;
      sense(s, r, e, q);
      if (!r && lat == 1 && mode == 1) drive(s, NONE, 32'd0, 32'd0);
      if (!r && mode == 2) drive(s, 2'($urandom), $urandom, $urandom);
    end
    done_cyc = cyc;
    if (mode == 2) drive(s, 2'($urandom), $urandom, $urandom);
    else           drive(s, NONE, 32'd0, 32'd0);
    check("latency", 32'(lat), 32'(wait_of(s) + 1));
    err = (a[1:0] != 2'b00) || (a[31:9] != 23'd0);
    if (t == WR && !err) ref_mem[s][a[8:2]] = d;
    if (t == RD || t == EX) ref_out[s] = err ? 32'hDEADBEEF : ref_mem[s][a[8:2]];
    check("err", {31'd0, e}, {31'd0, err});
    check("data", q, ref_out[s]);
  endtask

  task automatic quiet(input int s, input int n);
    logic r, e;
    logic [31:0] q;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sense(s, r, e, q);
      check("no_ready", {31'd0, r}, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom % 8)
      6:       a = {23'd0, 7'($urandom), 2'($urandom % 3 + 1)};
      7:       a = {23'($urandom % 8388607 + 1), 9'($urandom)};
      default: a = {23'd0, 7'($urandom), 2'b00};
    endcase
    return a;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, prev;
    logic r, e;
    logic [31:0] q;

    res2 = 1'b0; res0 = 1'b0;
    drive(0, NONE, 32'd0, 32'd0);
    drive(1, NONE, 32'd0, 32'd0);
    ref_out[0] = 32'd0; ref_out[1] = 32'd0;
    repeat (3) @(negedge clk);
    res2 = 1'b1; res0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sense(s, r, e, q);
        check("rst_ready", {31'd0, r}, 32'd0);
        check("rst_err",   {31'd0, e}, 32'd0);
        check("rst_data",  q, 32'd0);
      end
    end

    txn(0, WR, 32'h40, 32'h12345678, 0, dc);
    txn(0, RD, 32'h40, 32'd0, 0, dc);
    check("wr_rd_0x40", ref_out[0], 32'h12345678);

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 128; w++)
        txn(s, WR, 32'(w * 4), $urandom, 0, dc);

    txn(0, RD, 32'h42, 32'd0, 0, dc);
    txn(0, WR, 32'h200, 32'hCAFEF00D, 0, dc);
    txn(0, RD, 32'h0, 32'd0, 0, dc);

    txn(1, WR, 32'h0, 32'h20010040, 0, dc);
    txn(1, EX, 32'h0, 32'd0, 0, dc);
    for (int s = 0; s < 2; s++) begin
      txn(s, RD, rand_addr(), 32'd0, 0, prev);
      for (int i = 0; i < 6; i++) begin
        txn(s, 2'($urandom_range(1, 3)), rand_addr(), $urandom, 0, dc);
        check("throughput", 32'(dc - prev), 32'(wait_of(s) + 2));
        prev = dc;
      end
    end

    txn(0, WR, 32'h44, 32'h9, 1, dc);
    quiet(0, 4);
    txn(0, RD, 32'h44, 32'd0, 0, dc);

    txn(0, WR, 32'h48, 32'h5, 0, dc);
    @(negedge clk);
    drive(0, WR, 32'h48, 32'hAA);
    @(negedge clk);
    res2 = 1'b0;
    drive(0, NONE, 32'd0, 32'd0);
    ref_out[0] = 32'd0;
    quiet(0, 2);
    res2 = 1'b1;
    quiet(0, 3);
    sense(0, r, e, q);
    check("rst_mid_data", q, 32'd0);
    txn(0, RD, 32'h48, 32'd0, 0, dc);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 80; i++)
        txn(s, 2'($urandom_range(1, 3)), rand_addr(), $urandom, int'($urandom % 3), dc);
    drive(0, NONE, 32'd0, 32'd0);
    drive(1, NONE, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/db_ram_slave.md
# db_ram_slave

Word-addressed on-chip RAM slave for the CPU data bus. It sits directly downstream of `CPUCore` on the `db_*` bus and consumes its read, write and execute (fetch) requests. It inserts a programmable number of wait states and answers each request with a one-cycle `db_ready` pulse. It replaces the zero-latency behavioural memory so that the core's stall and handshake logic is exercised against a realistic slave.

## Interface
- `ADDR_WIDTH`, default 7: word-address bits. Capacity is 2^ADDR_WIDTH words; the default is 128 words (512 bytes).
- `WAIT_CYCLES`, default 2: wait states inserted between acceptance and `db_ready`. Legal range is 0..15.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `res`  input  1  asynchronous, active-low reset. It asserts when 0, independent of `clk`, and is released synchronously by the system.
- `db_addr`  input  32  byte address from the core.
- `db_dataOut`  input  32  write data from the core.
- `db_accessType`  input  2  request type, using the `DataBus.vh` encodings `MEM_ACCESS_NONE`, `MEM_ACCESS_R`, `MEM_ACCESS_W` and `MEM_ACCESS_X`.
- `db_dataIn`  output  32  read/fetch data returned to the core.
- `db_ready`  output  1  one-cycle completion pulse.
- `db_err`  output  1  error flag. It is valid only while `db_ready` = 1.

## Operation
- FSM states: IDLE, BUSY, ACK.
- **IDLE:**
  - If `db_accessType` ≠ NONE, the slave accepts the request at the rising edge.
  - On acceptance it latches the address, type and write data, and loads the counter with WAIT_CYCLES.
  - It then moves to BUSY, or directly to ACK when WAIT_CYCLES = 0.
- **BUSY:**
  - The counter decrements each cycle.
  - At the edge where the counter is 1, the slave performs the access and moves to ACK.
- **Access:** performed once, on the latched request.
  - R or X: `db_dataIn` ← `mem[addr[ADDR_WIDTH+1:2]]`.
  - W: `mem[...]` ← the latched data. `db_dataIn` is unchanged.
- **ACK:**
  - `db_ready` = 1 for exactly one cycle, then the FSM returns to IDLE.
  - The request presented during the ACK cycle is ignored. The core must sample `db_ready` and may only present a new request from the following cycle, when the FSM is in IDLE.
- **Error:** a request is an error if `db_addr[1:0]` ≠ 0 (misaligned) or `db_addr[31:ADDR_WIDTH+2]` ≠ 0 (out of range).
  - Errored writes are suppressed.
  - Errored reads and fetches return 32'hDEADBEEF.
  - `db_err` = 1 during ACK. The full wait-state count still applies.
- **Latched request:** the request is latched at acceptance. Later changes to the `db_*` inputs, including a drop to NONE, do not affect the access in flight.
- **Data hold:** `db_dataIn` holds its last value until the next completed read or fetch.
- **Memory contents:** RAM is not cleared by reset.

## Timing
- **Reset values:** state = IDLE, counter = 0, `db_ready` = 0, `db_err` = 0, `db_dataIn` = 32'h0.
- **Latency:** a request first presented in IDLE cycle *n* gets `db_ready` high in cycle *n* + WAIT_CYCLES + 1. `db_dataIn` is valid in that same cycle.
- **Throughput:** back-to-back requests complete one every WAIT_CYCLES + 2 cycles.
- **Reset mid-transaction:** reset during BUSY or ACK aborts the access. Any pending write is not performed, no `db_ready` pulse is produced, and the FSM is in IDLE on release.
- **Register map:** `db_ready`, `db_err` and `db_dataIn` are registered outputs. There is no combinational path from inputs to outputs.

## Configuration
- **`DB_RAM_TRACE_EN` defined:** each completed access prints one simulation line via `$display` showing the type, address, data and error flag. Accepted requests are not traced. Execute accesses are highlighted with `FONT_YELLOW` from `font.vh`.
- **`DB_RAM_TRACE_EN` undefined:** no simulation output.
- Ports, timing and memory behaviour are identical in both cases. Trace code must be synthesis-neutral.

## Test plan
- **Reset:** hold `res` = 0, then release. Expect `db_ready` = 0, `db_err` = 0 and `db_dataIn` = 0 until the first request.
- **Write then read, default latency:** W addr 0x40, data 0x12345678, then R addr 0x40, with WAIT_CYCLES = 2. Each request gives `db_ready` exactly 3 cycles after presentation. The read returns 0x12345678 with `db_err` = 0.
- **Zero wait states:** set WAIT_CYCLES = 0 and issue X at addr 0x0 with `mem[0]` preloaded to 0x20010040. Expect `db_ready` in the cycle after presentation with `db_dataIn` = 0x20010040. Then issue back-to-back requests and check one completion every 2 cycles.
- **Errors:**
  - R at 0x42 (misaligned): `db_err` = 1 and `db_dataIn` = 0xDEADBEEF.
  - W at 0x200 (out of range for ADDR_WIDTH 7): `db_err` = 1, and a following read of word 0 shows it unchanged.
- **Request changed mid-flight:** accept W addr 0x44, data 0x9, then switch the inputs to NONE and data 0x0 during BUSY. Expect `mem[17]` = 0x9 and a single `db_ready` pulse.
- **Reset mid-write:** pull `res` low in the BUSY cycle of W addr 0x48, data 0xAA (cell preloaded 0x5). Expect no `db_ready`, and a read after release returns 0x5.
